// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Returned to a master whose transfer was cut short by the stall watchdog.
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Combinational winner selection between two requesters.
module mem_bus_rr_pick #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic pick0,
    output logic pick1
);

    // last_grant = 1 means m1 owned the bus last, so m0 wins a round-robin tie.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (req0 && req1) begin
            if (PRIORITY_MODE != 0 || last_grant) begin
                pick0 = 1'b1;
            end else begin
                pick1 = 1'b1;
            end
        end else begin
            pick0 = req0;
            pick1 = req1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave arbiter for the waitrequest-style memory bus,
// one transfer per grant with an idle bubble, plus a stall watchdog.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);

    arb_state_t        state_reg;
    logic [1:0]        grant_reg;
    logic              last_grant_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic              timeout_err_reg;
    logic [1:0]        release_reg;

    logic [1:0]        req;
    logic [1:0]        wait_vec;
    logic [DATA_W-1:0] rdata_vec [2];
    logic              pick0;
    logic              pick1;
    logic              cur_req;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign cur_req = |(req & grant_reg);

    // A master being released by the watchdog is still holding its old request
    // during the release cycle, so it must not take part in that arbitration.
    mem_bus_rr_pick #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_pick (
        .req0      (req[0] & ~release_reg[0]),
        .req1      (req[1] & ~release_reg[1]),
        .last_grant(last_grant_reg),
        .pick0     (pick0),
        .pick1     (pick1)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign wait_vec[gi]  = grant_reg[gi] ? s_waitrequest : ~release_reg[gi];
        assign rdata_vec[gi] = grant_reg[gi]   ? s_readdata :
                               release_reg[gi] ? TIMEOUT_RDATA : '0;
    end

    assign m0_waitrequest = wait_vec[0];
    assign m1_waitrequest = wait_vec[1];
    assign m0_readdata    = rdata_vec[0];
    assign m1_readdata    = rdata_vec[1];
    assign grant          = grant_reg;
    assign timeout_err    = timeout_err_reg;

    // A simultaneous read+write from a master is forwarded as a write only.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (grant_reg[0]) begin
            s_address    = m0_address;
            s_read       = m0_read & ~m0_write;
            s_write      = m0_write;
            s_writedata  = m0_writedata;
            s_byteenable = m0_byteenable;
        end else if (grant_reg[1]) begin
            s_address    = m1_address;
            s_read       = m1_read & ~m1_write;
            s_write      = m1_write;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= 2'b00;
            last_grant_reg  <= 1'b1;
            wdog_reg        <= '0;
            timeout_err_reg <= 1'b0;
            release_reg     <= 2'b00;
        end else begin
            release_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (pick0) begin
                        state_reg      <= GNT0;
                        grant_reg      <= 2'b01;
                        last_grant_reg <= 1'b0;
                        wdog_reg       <= '0;
                    end else if (pick1) begin
                        state_reg      <= GNT1;
                        grant_reg      <= 2'b10;
                        last_grant_reg <= 1'b1;
                        wdog_reg       <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (!cur_req || !s_waitrequest) begin
                        state_reg <= IDLE;
                        grant_reg <= 2'b00;
                    end else if (wdog_reg >= WDOG_MAX - WDOG_W'(1)) begin
                        state_reg       <= IDLE;
                        grant_reg       <= 2'b00;
                        wdog_reg        <= WDOG_MAX;
                        timeout_err_reg <= 1'b1;
                        release_reg     <= grant_reg;
                    end else begin
                        wdog_reg <= wdog_reg + WDOG_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Two arbiter instances (round-robin and fixed priority, watchdog of 8) each
// driving a delay-1 RAM model; a scoreboard checks completed transfers in order.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        m_read  [2][2];
    logic        m_write [2][2];
    logic        m_wait  [2][2];
    logic [31:0] m_addr  [2][2];
    logic [31:0] m_wdata [2][2];
    logic [31:0] m_rdata [2][2];
    logic [3:0]  m_be    [2][2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [31:0] s_rdata [2];
    logic [3:0]  s_be    [2];
    logic        s_rd    [2];
    logic        s_wr    [2];
    logic        s_wait  [2];
    logic        tmo     [2];
    logic [1:0]  grant   [2];
    logic        stall   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          inst;
        int          mst;
        logic        is_rd;
        logic [31:0] rdata;
        int          gap;
    } exp_t;

    exp_t exp_q[$];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] mem [0:1023];
        logic        ack;
        logic [31:0] rdata_q;

        mem_bus_arbiter #(
            .PRIORITY_MODE (gi),
            .TIMEOUT_CYCLES(8)
        ) dut (
            .clk           (clk),
            .rst           (rst[gi]),
            .m0_address    (m_addr[gi][0]),
            .m0_read       (m_read[gi][0]),
            .m0_write      (m_write[gi][0]),
            .m0_writedata  (m_wdata[gi][0]),
            .m0_byteenable (m_be[gi][0]),
            .m0_waitrequest(m_wait[gi][0]),
            .m0_readdata   (m_rdata[gi][0]),
            .m1_address    (m_addr[gi][1]),
            .m1_read       (m_read[gi][1]),
            .m1_write      (m_write[gi][1]),
            .m1_writedata  (m_wdata[gi][1]),
            .m1_byteenable (m_be[gi][1]),
            .m1_waitrequest(m_wait[gi][1]),
            .m1_readdata   (m_rdata[gi][1]),
            .s_address     (s_addr[gi]),
            .s_read        (s_rd[gi]),
            .s_write       (s_wr[gi]),
            .s_writedata   (s_wdata[gi]),
            .s_byteenable  (s_be[gi]),
            .s_waitrequest (s_wait[gi]),
            .s_readdata    (s_rdata[gi]),
            .grant         (grant[gi]),
            .timeout_err   (tmo[gi])
        );

        // Delay-1 RAM: one wait cycle per access; stall holds waitrequest high.
        assign s_wait[gi]  = stall[gi] | ((s_rd[gi] | s_wr[gi]) & ~ack);
        assign s_rdata[gi] = rdata_q;

        always @(posedge clk) begin
            if (rst[gi]) begin
                ack <= 1'b0;
            end else begin
                ack <= (s_rd[gi] | s_wr[gi]) & ~ack & ~stall[gi];
                if ((s_rd[gi] | s_wr[gi]) && !ack)
                    rdata_q <= mem[s_addr[gi][11:2]];
                if (s_wr[gi] && !s_wait[gi])
                    for (int b = 0; b < 4; b++)
                        if (s_be[gi][b])
                            mem[s_addr[gi][11:2]][8*b +: 8] <= s_wdata[gi][8*b +: 8];
            end
        end

        initial begin
            rdata_q = 32'h0;
            for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
            mem[10'h040] = 32'h1234_5678;
            mem[10'h080] = 32'hA5A5_A5A5;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input int i, input int j, input logic is_rd,
                              input logic [31:0] rdata, input int gap);
        exp_t e;
        e.inst  = i;
        e.mst   = j;
        e.is_rd = is_rd;
        e.rdata = rdata;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    task automatic bus_op(input int i, input int j, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        int n;
        n = 0;
        m_addr[i][j]  = addr;
        m_wdata[i][j] = data;
        m_be[i][j]    = be;
        m_write[i][j] = wr;
        m_read[i][j]  = ~wr;
        do begin
            @(negedge clk);
            n++;
        end while (m_wait[i][j] && n < 200);
        chk("op_complete_bound", {31'b0, m_wait[i][j]}, 32'd0);
        @(posedge clk);
        #1;
        m_read[i][j]  = 1'b0;
        m_write[i][j] = 1'b0;
    endtask

    task automatic do_reset(input int i);
        @(posedge clk);
        #1;
        rst[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed master transfer pops the next expected entry.
    initial begin
        exp_t e;
        int   last_cyc [2];
        last_cyc[0] = 0;
        last_cyc[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if ((m_read[i][j] || m_write[i][j]) && !m_wait[i][j] && !rst[i]) begin
                        $display("txn cyc=%0d inst=%0d m%0d %s addr=%h rdata=%h",
                                 cyc, i, j, m_write[i][j] ? "wr" : "rd", m_addr[i][j], m_rdata[i][j]);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_txn", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("txn_inst", i, e.inst);
                            chk("txn_master", j, e.mst);
                            if (e.is_rd) chk("txn_rdata", m_rdata[i][j], e.rdata);
                            if (e.gap >= 0) chk("txn_gap", cyc - last_cyc[i], e.gap);
                        end
                        last_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]   = 1'b1;
            stall[i] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                m_read[i][j]  = 1'b0;
                m_write[i][j] = 1'b0;
                m_addr[i][j]  = 32'h0;
                m_wdata[i][j] = 32'h0;
                m_be[i][j]    = 4'h0;
            end
        end
        repeat (2) @(negedge clk);
        chk("rst_grant", grant[0], 2'b00);
        chk("rst_timeout_err", tmo[0], 1'b0);
        chk("rst_m0_wait", m_wait[0][0], 1'b1);
        chk("rst_m1_wait", m_wait[0][1], 1'b1);
        chk("rst_s_read", s_rd[0], 1'b0);
        chk("rst_s_write", s_wr[0], 1'b0);
        chk("rst_s_address", s_addr[0], 32'h0);
        chk("rst_m0_rdata", m_rdata[0][0], 32'h0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // Single m0 read of 0x100.
        expect_txn(0, 0, 1'b1, 32'h1234_5678, -1);
        fork
            bus_op(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
            begin
                @(negedge clk);
                chk("t1_grant_req_cycle", grant[0], 2'b00);
                @(negedge clk);
                chk("t1_grant", grant[0], 2'b01);
                chk("t1_s_read", s_rd[0], 1'b1);
                chk("t1_s_address", s_addr[0], 32'h100);
                chk("t1_m0_wait_first", m_wait[0][0], 1'b1);
                chk("t1_m1_wait_a", m_wait[0][1], 1'b1);
                @(negedge clk);
                chk("t1_m0_wait_done", m_wait[0][0], 1'b0);
                chk("t1_m0_rdata", m_rdata[0][0], 32'h1234_5678);
                chk("t1_m1_wait_b", m_wait[0][1], 1'b1);
            end
        join

        // Round-robin: both masters stream 4 reads, completions alternate.
        do_reset(0);
        for (int k = 0; k < 4; k++) begin
            expect_txn(0, 0, 1'b1, 32'hC0DE_00C0 + k, (k == 0) ? -1 : 3);
            expect_txn(0, 1, 1'b1, 32'hC0DE_0100 + k, 3);
        end
        fork
            for (int k = 0; k < 4; k++) bus_op(0, 0, 1'b0, 32'h300 + 4 * k, 32'h0, 4'hF);
            for (int k = 0; k < 4; k++) bus_op(0, 1, 1'b0, 32'h400 + 4 * k, 32'h0, 4'hF);
        join

        // Fixed priority: all m0 transfers finish before m1 is served.
        do_reset(1);
        for (int k = 0; k < 4; k++) expect_txn(1, 0, 1'b1, 32'hC0DE_00C0 + k, (k == 0) ? -1 : 3);
        for (int k = 0; k < 4; k++) expect_txn(1, 1, 1'b1, 32'hC0DE_0100 + k, 3);
        fork
            for (int k = 0; k < 4; k++) bus_op(1, 0, 1'b0, 32'h300 + 4 * k, 32'h0, 4'hF);
            for (int k = 0; k < 4; k++) bus_op(1, 1, 1'b0, 32'h400 + 4 * k, 32'h0, 4'hF);
        join

        // Partial write from m1, then reads see only the low half changed.
        do_reset(0);
        expect_txn(0, 1, 1'b0, 32'h0, -1);
        expect_txn(0, 0, 1'b1, 32'hA5A5_F00D, 3);
        expect_txn(0, 1, 1'b1, 32'hA5A5_F00D, 3);
        bus_op(0, 1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'b0011);
        bus_op(0, 0, 1'b0, 32'h200, 32'h0, 4'hF);
        bus_op(0, 1, 1'b0, 32'h200, 32'h0, 4'hF);

        // Watchdog: stalled slave, m0 released with DEADBEEF, m1 served next.
        do_reset(0);
        stall[0] = 1'b1;
        expect_txn(0, 0, 1'b1, 32'hDEAD_BEEF, -1);
        expect_txn(0, 1, 1'b1, 32'hA5A5_F00D, -1);
        fork
            bus_op(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
            begin
                repeat (2) @(posedge clk);
                #1;
                bus_op(0, 1, 1'b0, 32'h200, 32'h0, 4'hF);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                chk("t5_tmo_before", tmo[0], 1'b0);
                chk("t5_grant_before", grant[0], 2'b01);
                @(negedge clk);
                chk("t5_tmo_set", tmo[0], 1'b1);
                chk("t5_grant_idle", grant[0], 2'b00);
                chk("t5_m0_wait_release", m_wait[0][0], 1'b0);
                chk("t5_m0_rdata_release", m_rdata[0][0], 32'hDEAD_BEEF);
                chk("t5_s_read_idle", s_rd[0], 1'b0);
                @(negedge clk);
                chk("t5_grant_m1", grant[0], 2'b10);
                stall[0] = 1'b0;
            end
        join
        @(negedge clk);
        chk("t5_tmo_sticky", tmo[0], 1'b1);

        // Asynchronous reset in the middle of a stalled m0 read.
        do_reset(0);
        chk("t6_tmo_cleared", tmo[0], 1'b0);
        stall[0]      = 1'b1;
        m_addr[0][0]  = 32'h100;
        m_read[0][0]  = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_grant_before", grant[0], 2'b01);
        chk("t6_s_read_before", s_rd[0], 1'b1);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("t6_s_read_async", s_rd[0], 1'b0);
        chk("t6_grant_async", grant[0], 2'b00);
        chk("t6_m0_wait_async", m_wait[0][0], 1'b1);
        m_read[0][0] = 1'b0;
        stall[0]     = 1'b0;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(posedge clk);
        #1;
        expect_txn(0, 0, 1'b1, 32'h1234_5678, -1);
        bus_op(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("t6_tmo_after", tmo[0], 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
